// File: rtl/dmem_arbiter_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
// Holds the FSM state encoding and a state-to-grant decode helper.
package dmem_arbiter_pkg;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_BUSY0 = 2'd1,
        ARB_BUSY1 = 2'd2
    } dmem_arb_state_t;

    localparam int DMEM_ARB_TIMEOUT_DEFAULT = 255;

    function automatic logic [1:0] arb_grant_onehot(input dmem_arb_state_t s);
        logic [1:0] g;
        g = 2'b00;
        case (s)
            ARB_BUSY0: g = 2'b01;
            ARB_BUSY1: g = 2'b10;
            default:   g = 2'b00;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_pick2.sv
// Combinational two-way round-robin winner selection.
// On a tie the requester that did not own the port last time wins.
module rr_pick2 (
    input  logic req0_i,
    input  logic req1_i,
    input  logic last_grant_i,
    output logic valid_o,
    output logic winner_o
);

    always_comb begin
        valid_o  = req0_i | req1_i;
        winner_o = 1'b0;
        if (req0_i && req1_i) begin
            winner_o = ~last_grant_i;
        end else if (req1_i) begin
            winner_o = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single data-memory port: round-robin grant,
// registered slave command, ack/rdata returned to the owner, watchdog error ack.
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = DMEM_ARB_TIMEOUT_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [AW-1:0]     m0_addr,
    input  logic [DW-1:0]     m0_wdata,
    input  logic [DW/8-1:0]   m0_be,
    output logic              m0_stall,
    output logic              m0_ack,
    output logic              m0_err,
    output logic [DW-1:0]     m0_rdata,

    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [AW-1:0]     m1_addr,
    input  logic [DW-1:0]     m1_wdata,
    input  logic [DW/8-1:0]   m1_be,
    output logic              m1_stall,
    output logic              m1_ack,
    output logic              m1_err,
    output logic [DW-1:0]     m1_rdata,

    output logic              s_req,
    output logic              s_we,
    output logic [AW-1:0]     s_addr,
    output logic [DW-1:0]     s_wdata,
    output logic [DW/8-1:0]   s_be,
    input  logic              s_stall,
    input  logic              s_ack,
    input  logic [DW-1:0]     s_rdata,

    output logic [1:0]        grant_o
);

    localparam int            TW     = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] T_SAT  = TW'(TIMEOUT);

    dmem_arb_state_t   state_q, state_d;
    logic              last_grant_q, last_grant_d;
    logic [TW-1:0]     timer_q, timer_d;
    logic              s_req_q, s_req_d;
    logic              s_we_q, s_we_d;
    logic [AW-1:0]     s_addr_q, s_addr_d;
    logic [DW-1:0]     s_wdata_q, s_wdata_d;
    logic [DW/8-1:0]   s_be_q, s_be_d;

    logic              pick_valid;
    logic              pick_winner;
    logic              done_c;
    logic              err_c;
    logic              accept0, accept1;

    rr_pick2 u_pick (
        .req0_i       (m0_req),
        .req1_i       (m1_req),
        .last_grant_i (last_grant_q),
        .valid_o      (pick_valid),
        .winner_o     (pick_winner)
    );

    assign accept0 = (state_q == ARB_IDLE) && pick_valid && !pick_winner;
    assign accept1 = (state_q == ARB_IDLE) && pick_valid &&  pick_winner;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        timer_d      = timer_q;
        s_req_d      = s_req_q;
        s_we_d       = s_we_q;
        s_addr_d     = s_addr_q;
        s_wdata_d    = s_wdata_q;
        s_be_d       = s_be_q;
        done_c       = 1'b0;
        err_c        = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_d      = pick_winner ? ARB_BUSY1 : ARB_BUSY0;
                    last_grant_d = pick_winner;
                    timer_d      = '0;
                    s_req_d      = 1'b1;
                    s_we_d       = pick_winner ? m1_we    : m0_we;
                    s_addr_d     = pick_winner ? m1_addr  : m0_addr;
                    s_wdata_d    = pick_winner ? m1_wdata : m0_wdata;
                    s_be_d       = pick_winner ? m1_be    : m0_be;
                end
            end
            ARB_BUSY0, ARB_BUSY1: begin
                // A real ack always beats the watchdog firing in the same cycle.
                if (s_ack) begin
                    done_c = 1'b1;
                end else if (timer_q == T_LAST) begin
                    done_c = 1'b1;
                    err_c  = 1'b1;
                end else begin
                    if (timer_q != T_SAT) begin
                        timer_d = timer_q + 1'b1;
                    end
                    if (!s_stall) begin
                        s_req_d = 1'b0;
                    end
                end
                if (done_c) begin
                    state_d = ARB_IDLE;
                    s_req_d = 1'b0;
                end
            end
            default: begin
                state_d = ARB_IDLE;
                s_req_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ARB_IDLE;
            last_grant_q <= 1'b1;
            timer_q      <= '0;
            s_req_q      <= 1'b0;
            s_we_q       <= 1'b0;
            s_addr_q     <= '0;
            s_wdata_q    <= '0;
            s_be_q       <= '0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            timer_q      <= timer_d;
            s_req_q      <= s_req_d;
            s_we_q       <= s_we_d;
            s_addr_q     <= s_addr_d;
            s_wdata_q    <= s_wdata_d;
            s_be_q       <= s_be_d;
        end
    end

    // Completion is gated by reset so an in-flight transaction is dropped silently.
    assign m0_ack   = done_c && (state_q == ARB_BUSY0) && !rst;
    assign m1_ack   = done_c && (state_q == ARB_BUSY1) && !rst;
    assign m0_err   = m0_ack && err_c;
    assign m1_err   = m1_ack && err_c;
    assign m0_rdata = (m0_ack && !err_c) ? s_rdata : '0;
    assign m1_rdata = (m1_ack && !err_c) ? s_rdata : '0;

    assign m0_stall = m0_req && !accept0;
    assign m1_stall = m1_req && !accept1;

    assign s_req    = s_req_q;
    assign s_we     = s_we_q;
    assign s_addr   = s_addr_q;
    assign s_wdata  = s_wdata_q;
    assign s_be     = s_be_q;
    assign grant_o  = arb_grant_onehot(state_q);

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter (TIMEOUT=8): reset, read, tie, slave stall,
// watchdog timeout, ack on the timeout cycle, reset during a transaction.
module tb_dmem_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          m0_req, m0_we, m0_stall, m0_ack, m0_err;
    logic [AW-1:0] m0_addr;
    logic [DW-1:0] m0_wdata, m0_rdata;
    logic [3:0]    m0_be;
    logic          m1_req, m1_we, m1_stall, m1_ack, m1_err;
    logic [AW-1:0] m1_addr;
    logic [DW-1:0] m1_wdata, m1_rdata;
    logic [3:0]    m1_be;
    logic          s_req, s_we, s_stall, s_ack;
    logic [AW-1:0] s_addr;
    logic [DW-1:0] s_wdata, s_rdata;
    logic [3:0]    s_be;
    logic [1:0]    grant_o;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    dmem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata), .m0_be(m0_be),
        .m0_stall(m0_stall), .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata), .m1_be(m1_be),
        .m1_stall(m1_stall), .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .s_req(s_req), .s_we(s_we), .s_addr(s_addr), .s_wdata(s_wdata), .s_be(s_be),
        .s_stall(s_stall), .s_ack(s_ack), .s_rdata(s_rdata),
        .grant_o(grant_o)
    );

    task automatic test_reset();
        rst = 1'b1; m0_req = 1'b1; m0_we = 1'b0; m0_addr = 32'h100; m0_wdata = '0; m0_be = 4'hF;
        m1_req = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0; m1_be = '0;
        s_stall = 1'b0; s_ack = 1'b0; s_rdata = '0;
        repeat (2) @(negedge clk);
        #1;
        vectors++; if (s_req !== 1'b0) begin miscompares++; $display("FAIL rst_s_req got %b want 0", s_req); end
        vectors++; if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL rst_m0_ack got %b want 0", m0_ack); end
        vectors++; if (grant_o !== 2'b00) begin miscompares++; $display("FAIL rst_grant got %b want 00", grant_o); end
        rst = 1'b0;
        #1;
        vectors++; if (m0_stall !== 1'b0) begin miscompares++; $display("FAIL rst_first_accept m0_stall got %b want 0", m0_stall); end
    endtask

    task automatic test_single_read();
        @(negedge clk); m0_req = 1'b0; #1;
        vectors++; if (s_req !== 1'b1) begin miscompares++; $display("FAIL rd_s_req got %b want 1", s_req); end
        vectors++; if (s_addr !== 32'h100) begin miscompares++; $display("FAIL rd_s_addr got %h want 00000100", s_addr); end
        vectors++; if (s_we !== 1'b0) begin miscompares++; $display("FAIL rd_s_we got %b want 0", s_we); end
        vectors++; if (grant_o !== 2'b01) begin miscompares++; $display("FAIL rd_grant got %b want 01", grant_o); end
        vectors++; if (m0_rdata !== 32'h0) begin miscompares++; $display("FAIL rd_rdata_idle got %h want 0", m0_rdata); end
        @(negedge clk); s_ack = 1'b1; s_rdata = 32'hDEADBEEF; #1;
        vectors++; if (m0_ack !== 1'b1) begin miscompares++; $display("FAIL rd_m0_ack got %b want 1", m0_ack); end
        vectors++; if (m0_rdata !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rd_m0_rdata got %h want deadbeef", m0_rdata); end
        vectors++; if (m0_err !== 1'b0) begin miscompares++; $display("FAIL rd_m0_err got %b want 0", m0_err); end
        vectors++; if (m1_ack !== 1'b0 || m1_rdata !== 32'h0 || m1_stall !== 1'b0) begin miscompares++;
            $display("FAIL rd_m1_untouched got ack=%b rdata=%h stall=%b want 0/0/0", m1_ack, m1_rdata, m1_stall); end
        vectors++; if (s_req !== 1'b0) begin miscompares++; $display("FAIL rd_s_req_drop got %b want 0", s_req); end
        @(negedge clk); s_ack = 1'b0; s_rdata = '0; #1;
        vectors++; if (m0_ack !== 1'b0 || grant_o !== 2'b00) begin miscompares++;
            $display("FAIL rd_after got ack=%b grant=%b want 0/00", m0_ack, grant_o); end
    endtask

    task automatic test_tie();
        rst = 1'b1; m0_req = 1'b1; m1_req = 1'b1; m0_addr = 32'h10; m1_addr = 32'h20;
        repeat (2) @(negedge clk);
        rst = 1'b0; #1;
        vectors++; if (m0_stall !== 1'b0 || m1_stall !== 1'b1) begin miscompares++;
            $display("FAIL tie_first got stall0=%b stall1=%b want 0/1", m0_stall, m1_stall); end
        @(negedge clk); #1;
        vectors++; if (grant_o !== 2'b01 || s_addr !== 32'h10) begin miscompares++;
            $display("FAIL tie_grant_m0 got grant=%b addr=%h want 01/10", grant_o, s_addr); end
        vectors++; if (m1_stall !== 1'b1 || m0_stall !== 1'b1) begin miscompares++;
            $display("FAIL tie_busy_stall got stall0=%b stall1=%b want 1/1", m0_stall, m1_stall); end
        @(negedge clk); s_ack = 1'b1; #1;
        vectors++; if (m0_ack !== 1'b1 || m1_ack !== 1'b0 || m1_stall !== 1'b1) begin miscompares++;
            $display("FAIL tie_ack0 got ack0=%b ack1=%b stall1=%b want 1/0/1", m0_ack, m1_ack, m1_stall); end
        @(negedge clk); s_ack = 1'b0; #1;
        vectors++; if (m1_stall !== 1'b0 || m0_stall !== 1'b1) begin miscompares++;
            $display("FAIL tie_second got stall0=%b stall1=%b want 1/0", m0_stall, m1_stall); end
        @(negedge clk); m1_req = 1'b0; #1;
        vectors++; if (grant_o !== 2'b10 || s_addr !== 32'h20) begin miscompares++;
            $display("FAIL tie_grant_m1 got grant=%b addr=%h want 10/20", grant_o, s_addr); end
        @(negedge clk); s_ack = 1'b1; #1;
        vectors++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0) begin miscompares++;
            $display("FAIL tie_ack1 got ack0=%b ack1=%b want 0/1", m0_ack, m1_ack); end
        @(negedge clk); s_ack = 1'b0; #1;
        vectors++; if (m0_stall !== 1'b0) begin miscompares++; $display("FAIL tie_third got stall0=%b want 0", m0_stall); end
        @(negedge clk); m0_req = 1'b0; #1;
        vectors++; if (grant_o !== 2'b01) begin miscompares++; $display("FAIL tie_grant_m0b got %b want 01", grant_o); end
        @(negedge clk); s_ack = 1'b1; #1;
        @(negedge clk); s_ack = 1'b0;
    endtask

    task automatic test_slave_stall();
        m1_req = 1'b1; m1_we = 1'b1; m1_addr = 32'h200; m1_be = 4'b0011; m1_wdata = 32'h0000ABCD;
        s_stall = 1'b1; #1;
        vectors++; if (m1_stall !== 1'b0) begin miscompares++; $display("FAIL st_accept got stall1=%b want 0", m1_stall); end
        for (int i = 1; i <= 4; i++) begin
            @(negedge clk); m1_req = 1'b0;
            if (i == 4) s_stall = 1'b0;
            #1;
            vectors++;
            if (s_req !== 1'b1 || s_addr !== 32'h200 || s_be !== 4'b0011 || s_wdata !== 32'h0000ABCD
                || s_we !== 1'b1 || grant_o !== 2'b10) begin
                miscompares++;
                $display("FAIL st_hold[%0d] got req=%b addr=%h be=%b wdata=%h we=%b grant=%b want 1/200/0011/0000abcd/1/10",
                         i, s_req, s_addr, s_be, s_wdata, s_we, grant_o);
            end
        end
        @(negedge clk); s_ack = 1'b1; #1;
        vectors++; if (s_req !== 1'b0) begin miscompares++; $display("FAIL st_s_req_drop got %b want 0", s_req); end
        vectors++; if (m1_ack !== 1'b1 || m0_ack !== 1'b0 || m1_err !== 1'b0) begin miscompares++;
            $display("FAIL st_ack_route got ack0=%b ack1=%b err1=%b want 0/1/0", m0_ack, m1_ack, m1_err); end
        @(negedge clk); s_ack = 1'b0; m1_we = 1'b0;
    endtask

    task automatic test_timeout();
        m0_req = 1'b1; m0_addr = 32'h300; s_rdata = 32'h12345678; #1;
        vectors++; if (m0_stall !== 1'b0) begin miscompares++; $display("FAIL to_accept got stall0=%b want 0", m0_stall); end
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); m0_req = 1'b0; #1;
            vectors++; if (m0_ack !== 1'b0) begin miscompares++; $display("FAIL to_early[%0d] got ack0=%b want 0", i, m0_ack); end
        end
        @(negedge clk); #1;
        vectors++; if (m0_ack !== 1'b1 || m0_err !== 1'b1 || m0_rdata !== 32'h0) begin miscompares++;
            $display("FAIL to_fire got ack=%b err=%b rdata=%h want 1/1/0", m0_ack, m0_err, m0_rdata); end
        vectors++; if (grant_o !== 2'b01 || s_req !== 1'b0) begin miscompares++;
            $display("FAIL to_fire_state got grant=%b s_req=%b want 01/0", grant_o, s_req); end
        @(negedge clk); s_ack = 1'b1; #1;
        vectors++; if (grant_o !== 2'b00 || m0_ack !== 1'b0 || m1_ack !== 1'b0) begin miscompares++;
            $display("FAIL to_stray got grant=%b ack0=%b ack1=%b want 00/0/0", grant_o, m0_ack, m1_ack); end
        @(negedge clk); s_ack = 1'b0;
    endtask

    task automatic test_ack_on_timeout();
        m0_req = 1'b1; m0_addr = 32'h304; #1;
        vectors++; if (m0_stall !== 1'b0) begin miscompares++; $display("FAIL at_accept got stall0=%b want 0", m0_stall); end
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk); m0_req = 1'b0;
        end
        @(negedge clk); s_ack = 1'b1; s_rdata = 32'hCAFEF00D; #1;
        vectors++; if (m0_ack !== 1'b1 || m0_err !== 1'b0 || m0_rdata !== 32'hCAFEF00D) begin miscompares++;
            $display("FAIL at_ack_wins got ack=%b err=%b rdata=%h want 1/0/cafef00d", m0_ack, m0_err, m0_rdata); end
        @(negedge clk); s_ack = 1'b0; s_rdata = '0; #1;
        vectors++; if (grant_o !== 2'b00) begin miscompares++; $display("FAIL at_idle got grant=%b want 00", grant_o); end
    endtask

    task automatic test_reset_busy();
        m1_req = 1'b1; m1_we = 1'b0; m1_addr = 32'h400; #1;
        vectors++; if (m1_stall !== 1'b0) begin miscompares++; $display("FAIL rb_accept got stall1=%b want 0", m1_stall); end
        @(negedge clk); m1_req = 1'b0; #1;
        vectors++; if (grant_o !== 2'b10) begin miscompares++; $display("FAIL rb_busy got grant=%b want 10", grant_o); end
        @(negedge clk); rst = 1'b1; #1;
        vectors++; if (m1_ack !== 1'b0) begin miscompares++; $display("FAIL rb_rst_ack got %b want 0", m1_ack); end
        @(negedge clk); rst = 1'b0; #1;
        vectors++; if (grant_o !== 2'b00 || s_req !== 1'b0 || s_addr !== 32'h0 || m1_ack !== 1'b0 || m1_stall !== 1'b0) begin
            miscompares++;
            $display("FAIL rb_after got grant=%b s_req=%b s_addr=%h ack1=%b stall1=%b want 00/0/0/0/0",
                     grant_o, s_req, s_addr, m1_ack, m1_stall);
        end
        @(negedge clk); s_ack = 1'b1; #1;
        vectors++; if (m1_ack !== 1'b0 || m0_ack !== 1'b0) begin miscompares++;
            $display("FAIL rb_stray got ack0=%b ack1=%b want 0/0", m0_ack, m1_ack); end
        @(negedge clk); s_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_tie();
        test_slave_stall();
        test_timeout();
        test_ack_on_timeout();
        test_reset_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
